// File: rtl/axi_axis_fifo_reader.sv
// AXI4-Stream capture FIFO exposed to software over AXI4-Lite.
// DATA pops the head, STATUS reports fill/flags, CONTROL sets mode/flush/clear, DROPS counts discards.
module axi_axis_fifo_reader #(
  parameter int AXI_ADDR_WIDTH  = 12,
  parameter int AXI_DATA_WIDTH  = 32,
  parameter int AXIS_DATA_WIDTH = 16,
  parameter int FIFO_DEPTH      = 16
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_awaddr,
  input  logic                       s_axi_awvalid,
  output logic                       s_axi_awready,
  input  logic [AXI_DATA_WIDTH-1:0]  s_axi_wdata,
  input  logic                       s_axi_wvalid,
  output logic                       s_axi_wready,
  output logic [1:0]                 s_axi_bresp,
  output logic                       s_axi_bvalid,
  input  logic                       s_axi_bready,
  input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  output logic [AXI_DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  localparam logic [1:0] A_DATA   = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_CTRL   = 2'd2;
  localparam logic [1:0] A_DROPS  = 2'd3;

  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;
  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [AXIS_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]              level_q, level_d;
  logic                       mode_q, mode_d;
  logic                       ovf_q, ovf_d;
  logic [31:0]                drops_q, drops_d;
  logic [0:0]                 r_state_q, r_state_d;
  logic [0:0]                 w_state_q, w_state_d;
  logic [AXI_DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic [1:0]                 rresp_q, rresp_d;
  logic                       arready_q, rvalid_q;
  logic                       awready_q, wready_q, bvalid_q;
  logic                       tready_q;

  logic                       ar_hs_s, w_hs_s, ctrl_wr_s, flush_s, clear_s;
  logic                       empty_s, full_s, full_d_s;
  logic                       beat_s, pop_s, push_s, drop_s;
  logic [1:0]                 ar_sel_s;
  logic [AXI_DATA_WIDTH-1:0]  status_s;
  logic                       unused_s;

  assign unused_s  = ^{s_axi_araddr, s_axi_awaddr, s_axi_wdata};

  assign ar_sel_s  = s_axi_araddr[3:2];
  assign ar_hs_s   = s_axi_arvalid && arready_q;
  assign w_hs_s    = s_axi_awvalid && s_axi_wvalid && awready_q && wready_q;
  assign ctrl_wr_s = w_hs_s && (s_axi_awaddr[3:2] == A_CTRL);
  assign flush_s   = ctrl_wr_s && s_axi_wdata[0];
  assign clear_s   = ctrl_wr_s && s_axi_wdata[1];

  assign empty_s   = (level_q == '0);
  assign full_s    = (level_q == DEPTH_L);
  assign beat_s    = s_axis_tvalid && tready_q;
  assign pop_s     = ar_hs_s && (ar_sel_s == A_DATA) && !empty_s;
  // A beat at full still lands when a pop frees a slot in the same cycle.
  assign push_s    = beat_s && (!full_s || pop_s);
  assign drop_s    = beat_s && full_s && !pop_s;
  assign full_d_s  = (level_d == DEPTH_L);

  always_comb begin
    status_s          = '0;
    status_s[0]       = empty_s;
    status_s[1]       = full_s;
    status_s[2]       = ovf_q;
    status_s[3]       = mode_q;
    status_s[16 +: LW] = level_q;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_s) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + 1'b1;
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + 1'b1;
      else        rd_ptr_d = rd_ptr_q;
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  // Clear outranks a same-cycle drop; a flush-cycle beat is neither stored nor counted.
  always_comb begin
    mode_d  = mode_q;
    ovf_d   = ovf_q;
    drops_d = drops_q;
    if (clear_s) begin
      ovf_d   = 1'b0;
      drops_d = 32'd0;
    end else if (drop_s && !flush_s) begin
      ovf_d   = 1'b1;
      drops_d = (drops_q == 32'hFFFF_FFFF) ? drops_q : drops_q + 32'd1;
    end else begin
      ovf_d   = ovf_q;
      drops_d = drops_q;
    end
    if (ctrl_wr_s) mode_d = s_axi_wdata[2];
    else           mode_d = mode_q;
  end

  always_comb begin
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_state_d = R_DATA;
          rresp_d   = RESP_OKAY;
          case (ar_sel_s)
            A_DATA: begin
              if (empty_s) begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
              end else begin
                rdata_d = AXI_DATA_WIDTH'(mem_q[rd_ptr_q]);
              end
            end
            A_STATUS: rdata_d = status_s;
            A_CTRL:   rdata_d = AXI_DATA_WIDTH'({mode_q, 2'b00});
            A_DROPS:  rdata_d = AXI_DATA_WIDTH'(drops_q);
            default:  rdata_d = '0;
          endcase
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (s_axi_rready) r_state_d = R_IDLE;
        else              r_state_d = R_DATA;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: begin
        if (w_hs_s) w_state_d = W_RESP;
        else        w_state_d = W_IDLE;
      end
      W_RESP: begin
        if (s_axi_bready) w_state_d = W_IDLE;
        else              w_state_d = W_RESP;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Handshake outputs are registered from next-state so they are all 0 in reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      mode_q    <= 1'b0;
      ovf_q     <= 1'b0;
      drops_q   <= 32'd0;
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      tready_q  <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      mode_q    <= mode_d;
      ovf_q     <= ovf_d;
      drops_q   <= drops_d;
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      arready_q <= (r_state_d == R_IDLE);
      rvalid_q  <= (r_state_d == R_DATA);
      awready_q <= (w_state_d == W_IDLE);
      wready_q  <= (w_state_d == W_IDLE);
      bvalid_q  <= (w_state_d == W_RESP);
      tready_q  <= mode_d || !full_d_s;
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge aclk) begin
    if (push_s && !flush_s) mem_q[wr_ptr_q] <= s_axis_tdata;
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axis_tready = tready_q;

endmodule

// File: tb/tb_axi_axis_fifo_reader.sv
// Scoreboard bench for axi_axis_fifo_reader: queue-based reference model, directed
// scenarios followed by randomized stream/register traffic.
module tb_axi_axis_fifo_reader;
  localparam int DEPTH = 16;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [11:0] s_axi_awaddr, s_axi_araddr;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_wdata, s_axi_rdata;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic [15:0] s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tready;

  always #5 aclk = ~aclk;

  axi_axis_fifo_reader #(.AXI_ADDR_WIDTH(12), .AXI_DATA_WIDTH(32),
                         .AXIS_DATA_WIDTH(16), .FIFO_DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready)
  );

  int total = 0;
  int bad = 0;
  int rd_issued = 0;
  int rd_done = 0;

  // reference model state
  logic [15:0] mq[$];
  bit          m_mode, m_ovf;
  logic [31:0] m_drops;

  // scoreboard of expected read responses
  logic [31:0] exp_d_q[$];
  logic [1:0]  exp_r_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s got=timeout want=handshake", nm);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = 32'h0;
    s[31:16] = 16'(mq.size());
    s[3] = m_mode;
    s[2] = m_ovf;
    s[1] = (mq.size() == DEPTH);
    s[0] = (mq.size() == 0);
    return s;
  endfunction

  function automatic void m_reset();
    mq.delete();
    m_mode  = 1'b0;
    m_ovf   = 1'b0;
    m_drops = 32'd0;
  endfunction

  function automatic void model_read(input logic [1:0] sel, output logic [31:0] d,
                                     output logic [1:0] r);
    r = 2'b00;
    case (sel)
      2'd0: begin
        if (mq.size() == 0) begin d = 32'd0; r = 2'b10; end
        else d = 32'(mq.pop_front());
      end
      2'd1: d = m_status();
      2'd2: d = {29'd0, m_mode, 2'b00};
      default: d = m_drops;
    endcase
  endfunction

  function automatic void model_write(input logic [1:0] sel, input logic [31:0] d);
    if (sel == 2'd2) begin
      if (d[0]) mq.delete();
      if (d[1]) begin m_drops = 32'd0; m_ovf = 1'b0; end
      m_mode = d[2];
    end
  endfunction

  // Monitor: every completed R handshake is checked against the scoreboard.
  always @(negedge aclk) begin
    logic [31:0] ed;
    logic [1:0]  er;
    if (aresetn === 1'b1 && s_axi_rvalid && s_axi_rready) begin
      if (exp_d_q.size() == 0) begin
        chk("r_unexpected", 64'(s_axi_rvalid), 64'd0);
      end else begin
        ed = exp_d_q.pop_front();
        er = exp_r_q.pop_front();
        chk("rdata", 64'(s_axi_rdata), 64'(ed));
        chk("rresp", 64'(s_axi_rresp), 64'(er));
        rd_done++;
      end
    end
  end

  task automatic push_beat(input logic [15:0] d);
    logic exp_rdy;
    tick();
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    exp_rdy = m_mode ? 1'b1 : (mq.size() < DEPTH);
    chk("tready", 64'(s_axis_tready), 64'(exp_rdy));
    if (mq.size() < DEPTH) mq.push_back(d);
    else if (m_mode) begin
      m_ovf = 1'b1;
      if (m_drops != 32'hFFFF_FFFF) m_drops++;
    end
  endtask

  task automatic stream_idle();
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [1:0] sel, input int hold);
    logic [31:0] ed;
    logic [1:0]  er;
    logic [11:0] a;
    int n;
    tick();
    n = 0;
    while (!s_axi_arready && n < 20) begin tick(); n++; end
    if (!s_axi_arready) begin fail_now("arready_wait"); return; end
    model_read(sel, ed, er);
    exp_d_q.push_back(ed);
    exp_r_q.push_back(er);
    rd_issued++;
    a = 12'($urandom);
    a[3:2] = sel;
    s_axi_araddr  = a;
    s_axi_arvalid = 1'b1;
    s_axi_rready  = (hold == 0);
    tick();
    s_axi_arvalid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      chk("hold_rvalid", 64'(s_axi_rvalid), 64'd1);
      chk("hold_arready", 64'(s_axi_arready), 64'd0);
      chk("hold_rdata", 64'(s_axi_rdata), 64'(ed));
      tick();
    end
    s_axi_rready = 1'b1;
    n = 0;
    while (rd_done != rd_issued && n < 20) begin tick(); n++; end
    if (rd_done != rd_issued) begin
      fail_now("rvalid_wait");
      void'(exp_d_q.pop_back());
      void'(exp_r_q.pop_back());
      rd_issued--;
    end
    s_axi_rready = 1'b0;
  endtask

  task automatic axi_write(input logic [1:0] sel, input logic [31:0] d, input bit beat,
                           input logic [15:0] bd);
    logic [11:0] a;
    int n;
    tick();
    n = 0;
    while (!(s_axi_awready && s_axi_wready) && n < 20) begin tick(); n++; end
    if (!(s_axi_awready && s_axi_wready)) begin fail_now("awready_wait"); return; end
    a = 12'($urandom);
    a[3:2] = sel;
    s_axi_awaddr  = a;
    s_axi_wdata   = d;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_bready  = 1'b1;
    if (beat) begin s_axis_tvalid = 1'b1; s_axis_tdata = bd; end
    model_write(sel, d);
    tick();
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axis_tvalid = 1'b0;
    n = 0;
    while (!s_axi_bvalid && n < 20) begin tick(); n++; end
    chk("bvalid", 64'(s_axi_bvalid), 64'd1);
    chk("bresp", 64'(s_axi_bresp), 64'd0);
    tick();
    s_axi_bready = 1'b0;
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({s_axi_arready, s_axi_awready, s_axi_wready, s_axis_tready, s_axi_rvalid,
                s_axi_bvalid, s_axi_rresp, s_axi_bresp, s_axi_rdata});
  endfunction

  initial begin
    aresetn = 1'b0;
    s_axi_awaddr = 12'd0; s_axi_awvalid = 1'b0; s_axi_wdata = 32'd0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0; s_axi_araddr = 12'd0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
    s_axis_tdata = 16'd0; s_axis_tvalid = 1'b0;
    m_reset();
    #22;
    chk("reset_outputs", out_vec(), 64'd0);
    tick();
    aresetn = 1'b1;
    tick();
    chk("ready_after_reset", 64'({s_axi_arready, s_axi_awready, s_axi_wready, s_axis_tready}),
        64'hF);

    // basic push / pop, empty read
    push_beat(16'h0035); push_beat(16'h1234); push_beat(16'hBEEF); stream_idle();
    for (int i = 0; i < 4; i++) axi_read(2'd0, 0);
    axi_read(2'd1, 0);

    // backpressure fill, then pop with a stalled beat waiting
    for (int i = 0; i < DEPTH; i++) push_beat(16'(16'h0100 + i));
    push_beat(16'h0110);
    axi_read(2'd1, 0);
    axi_read(2'd0, 0);
    mq.push_back(16'h0110);
    stream_idle();
    axi_read(2'd1, 0);
    for (int i = 0; i < DEPTH; i++) axi_read(2'd0, 0);

    // drop mode overflow, then clear keeping mode
    axi_write(2'd2, 32'h4, 1'b0, 16'h0);
    for (int i = 0; i < 20; i++) push_beat(16'(16'h0200 + i));
    stream_idle();
    axi_read(2'd3, 0);
    axi_read(2'd1, 0);
    for (int i = 0; i < DEPTH; i++) axi_read(2'd0, 0);
    axi_write(2'd2, 32'h6, 1'b0, 16'h0);
    axi_read(2'd3, 0);
    axi_read(2'd1, 0);
    axi_read(2'd2, 0);
    axi_write(2'd2, 32'h0, 1'b0, 16'h0);

    // flush with a coincident stream beat
    for (int i = 0; i < 5; i++) push_beat(16'(16'h0300 + i));
    stream_idle();
    axi_write(2'd2, 32'h1, 1'b1, 16'hDEAD);
    axi_read(2'd1, 0);
    axi_read(2'd3, 0);
    axi_read(2'd0, 0);

    // read-only write has no effect; long rready stall
    push_beat(16'h0501); push_beat(16'h0502); stream_idle();
    axi_write(2'd0, 32'hFFFF_FFFF, 1'b0, 16'h0);
    axi_read(2'd0, 10);
    axi_read(2'd1, 0);
    axi_read(2'd0, 0);

    // reset while rvalid is pending
    axi_write(2'd2, 32'h4, 1'b0, 16'h0);
    for (int i = 0; i < 8; i++) push_beat(16'(16'h0600 + i));
    stream_idle();
    tick();
    s_axi_araddr = 12'h000; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    tick();
    s_axi_arvalid = 1'b0;
    chk("rvalid_pre_reset", 64'(s_axi_rvalid), 64'd1);
    #2 aresetn = 1'b0;
    #1 chk("reset_mid_outputs", out_vec(), 64'd0);
    m_reset();
    tick(); tick();
    aresetn = 1'b1;
    tick();
    chk("ready_after_reset2",
        64'({s_axi_arready, s_axi_awready, s_axi_wready, s_axis_tready, s_axi_rvalid}), 64'h1E);
    axi_read(2'd1, 0);
    axi_read(2'd2, 0);

    // randomized traffic
    for (int op = 0; op < 150; op++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        int len;
        len = $urandom_range(1, 8);
        for (int j = 0; j < len; j++) push_beat(16'($urandom));
        stream_idle();
      end else if (kind < 8) begin
        axi_read(2'($urandom), 0);
      end else begin
        logic [31:0] wd;
        wd = $urandom;
        if ($urandom_range(0, 3) != 0) wd[0] = 1'b0;
        axi_write(2'($urandom), wd, 1'b0, 16'h0);
      end
    end
    axi_read(2'd1, 0);
    axi_read(2'd3, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "global timeout");
  end
endmodule
